// File: rtl/filter_window_sequencer.sv
// filter_window_sequencer: walks a source frame in raster order, fetches the
// 3x3 edge-clamped neighbourhood of every pixel (one read per cycle), presents
// it to an external filter core as one registered 108-bit window, and writes
// the filter result back to the destination frame FILTER_LAT cycles later.
// Ports:
//   clk, reset (sync, active-low), start -> frame request, busy/done status
//   rd_en/rd_addr/rd_data              -> source frame, 1-cycle read latency
//   color_data/win_valid               -> window to the filter core
//   filter_rgb_in                      -> filter core result
//   wr_en/wr_addr/wr_data              -> destination frame write port
module filter_window_sequencer #(
  parameter int unsigned IMG_W      = 64,
  parameter int unsigned IMG_H      = 48,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FILTER_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic [107:0]      color_data,
  output logic              win_valid,
  input  logic [11:0]       filter_rgb_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data
);

  localparam int unsigned PIX_W = 12;
  localparam int unsigned WIN_W = 9 * PIX_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [ADDR_W-1:0] X_MAX  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] Y_MAX  = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_SZ = ADDR_W'(IMG_W);
  localparam logic [3:0]        K_LAST = 4'd8;

  logic [2:0]        state, state_d;
  logic [ADDR_W-1:0] x, x_d, y, y_d;
  logic [3:0]        k, k_d;
  logic              issue, finish;
  logic [ADDR_W-1:0] rd_addr_d, pix_addr;
  logic              prev_rd;
  logic [WIN_W-1:0]  staging;
  logic [FILTER_LAT-1:0] dl_vld;
  logic [ADDR_W-1:0]     dl_addr [FILTER_LAT];

  // Address of neighbour k of (px,py) in fetch order, clamped to the frame.
  function automatic logic [ADDR_W-1:0] nbr_addr(input logic [ADDR_W-1:0] px,
                                                  input logic [ADDR_W-1:0] py,
                                                  input logic [3:0]        kk);
    logic [ADDR_W-1:0] xl, xr, yu, yd, nx, ny;
    xl = (px == '0)    ? px : px - ADDR_W'(1);
    xr = (px == X_MAX) ? px : px + ADDR_W'(1);
    yu = (py == '0)    ? py : py - ADDR_W'(1);
    yd = (py == Y_MAX) ? py : py + ADDR_W'(1);
    nx = px;
    ny = py;
    case (kk)
      4'd1: nx = xl;
      4'd2: nx = xr;
      4'd3: ny = yu;
      4'd4: ny = yd;
      4'd5: begin nx = xl; ny = yu; end
      4'd6: begin nx = xr; ny = yu; end
      4'd7: begin nx = xl; ny = yd; end
      4'd8: begin nx = xr; ny = yd; end
      default: ;
    endcase
    return ny * ROW_SZ + nx;
  endfunction

  // Next-state and counter logic.
  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    k_d     = k;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
        end
      end
      S_FETCH: begin
        if (k == K_LAST) begin
          state_d = S_WAIT;
          k_d     = '0;
        end else begin
          k_d = k + 4'd1;
        end
      end
      S_WAIT: state_d = S_ISSUE;
      S_ISSUE: begin
        issue = 1'b1;
        if (x == X_MAX && y == Y_MAX) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FETCH;
          if (x == X_MAX) begin
            x_d = '0;
            y_d = y + ADDR_W'(1);
          end else begin
            x_d = x + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (dl_vld == '0) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d = nbr_addr(x_d, y_d, k_d);
    pix_addr  = nbr_addr(x, y, 4'd0);
  end

  // Filter result passes straight through; only its timing is qualified by wr_en.
  assign wr_data = filter_rgb_in;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      k          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      prev_rd    <= 1'b0;
      staging    <= '0;
      color_data <= '0;
      win_valid  <= 1'b0;
      dl_vld     <= '0;
      for (int i = 0; i < int'(FILTER_LAT); i++) dl_addr[i] <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
    end else begin
      state   <= state_d;
      x       <= x_d;
      y       <= y_d;
      k       <= k_d;
      busy    <= (state_d != S_IDLE);
      done    <= finish;
      rd_en   <= (state_d == S_FETCH);
      rd_addr <= (state_d == S_FETCH) ? rd_addr_d : '0;
      prev_rd <= rd_en;
      // Read data lands one cycle after its request; shifting in keeps the
      // first-fetched (original) pixel at the top of the window.
      if (prev_rd) staging <= {staging[WIN_W-PIX_W-1:0], rd_data};
      win_valid <= issue;
      if (issue) color_data <= staging;
      // Tagged delay line: entry i holds the pixel issued i+1 cycles ago.
      for (int i = int'(FILTER_LAT) - 1; i > 0; i--) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_addr[i] <= dl_addr[i-1];
      end
      dl_vld[0]  <= issue;
      dl_addr[0] <= pix_addr;
      wr_en      <= dl_vld[FILTER_LAT-1];
      wr_addr    <= dl_vld[FILTER_LAT-1] ? dl_addr[FILTER_LAT-1] : '0;
    end
  end

endmodule
